// File: rtl/accel_result_drain.sv
// accel_result_drain
// Snapshots the accelerator's N*N-word result on each rising edge of done_in
// and streams the captured words out row-major over a valid/ready interface.
// The shadow copy lets the accelerator start its next job while draining.
module accel_result_drain #(
    parameter  int N    = 4,
    parameter  int W    = 32,
    localparam int IDXW = $clog2(N*N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done_in,
    input  logic [N*N*W-1:0]    result_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic [IDXW-1:0]     out_index,
    output logic                out_last,
    output logic                busy,
    output logic                overrun,
    input  logic                clear_overrun
);

    localparam int            NW       = N*N;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NW-1);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_done_d;
    logic [IDXW-1:0] r_index;
    logic [W-1:0]    r_shadow [NW];
    logic            r_overrun;

    logic            w_rise;
    logic            w_hs;
    logic            w_at_last;
    logic            w_final_hs;
    logic            w_capture;
    logic            w_drop;

    // A rise is accepted when idle, or when it lands exactly on the final
    // handshake so back-to-back jobs stream without a bubble. Any other rise
    // during a drain is dropped and flagged.
    assign w_rise     = done_in & ~r_done_d;
    assign w_hs       = out_valid & out_ready;
    assign w_at_last  = (r_index == LAST_IDX);
    assign w_final_hs = w_hs & w_at_last;
    assign w_capture  = w_rise & ((r_state == S_IDLE) | w_final_hs);
    assign w_drop     = w_rise & (r_state == S_DRAIN) & ~w_final_hs;

    // Delayed copy of done_in for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_done_d <= 1'b0;
        else     r_done_d <= done_in;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_final_hs && !w_rise) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from state, index and shadow buffer
    always_comb begin
        out_valid = (r_state == S_DRAIN);
        busy      = (r_state == S_DRAIN);
        out_index = r_index;
        out_last  = (r_state == S_DRAIN) & w_at_last;
        out_data  = (r_state == S_DRAIN) ? r_shadow[r_index] : '0;
        overrun   = r_overrun;
    end

    // Word index: restarts on capture or after the last word, steps on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else if (w_capture || w_final_hs) begin
            r_index <= '0;
        end else if (w_hs) begin
            r_index <= r_index + IDXW'(1);
        end
    end

    // Shadow buffer: result_flat is sampled only on an accepted capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NW; k++) r_shadow[k] <= '0;
        end else if (w_capture) begin
            for (int k = 0; k < NW; k++) r_shadow[k] <= result_flat[k*W +: W];
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_overrun <= 1'b0;
        else if (w_drop)        r_overrun <= 1'b1;
        else if (clear_overrun) r_overrun <= 1'b0;
    end

endmodule
